qtab_store: RTL and testbench
=============================

# qtab_store

Multi-table, run-time loadable inverse-quantization coefficient store for the JPEG decode path. It supersedes the fixed single-table 64×8 quantization ROM. It holds NUM_TABLES tables of 64 coefficients each, loaded from the DQT segment stream through a valid/ready handshake. It serves registered one-cycle-latency reads to the dequantizer, addressed by table id and natural (raster) coefficient index.

## Interface
- DATA_W, 8: coefficient width; 8 for baseline, 16 for 16-bit DQT precision.
- NUM_TABLES, 4: number of tables; legal range 1..4.
- TID_W (localparam): max(1, clog2(NUM_TABLES)).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_start  in  1  begin loading table ld_tid; sampled every cycle.
- ld_tid  in  TID_W  target table, captured when ld_start is high.
- ld_valid  in  1  ld_data is valid this cycle.
- ld_data  in  DATA_W  coefficient, delivered in DQT (zigzag) order.
- ld_ready  out  1  store accepts ld_data this cycle.
- ld_busy  out  1  a load is in progress.
- ld_done  out  1  one-cycle pulse: the 64th coefficient was written.
- rd_en  in  1  read request.
- rd_tid  in  TID_W  table to read.
- rd_addr  in  6  natural-order coefficient index (row*8+col).
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data updated this cycle.
- tbl_valid  out  NUM_TABLES  bit t high when table t is completely loaded.

## Operation
- FSM states:
  - IDLE: ld_ready=0, ld_busy=0.
  - LOAD: ld_ready=1, ld_busy=1.
- IDLE→LOAD on ld_start. On that transition: cnt←0, tid_r←ld_tid, tbl_valid[ld_tid]←0.
- In LOAD, each cycle with ld_valid&ld_ready:
  - writes ld_data to mem[tid_r][wa(cnt)];
  - increments the 6-bit cnt.
- The beat accepted at cnt==63:
  - next state IDLE;
  - ld_done=1 for one cycle;
  - tbl_valid[tid_r]←1.
- Load-side boundary conditions:
  - ld_start in LOAD restarts the load: cnt←0, new tid_r captured, tbl_valid[new tid]←0. The beat presented in that same cycle is discarded. The abandoned table's tbl_valid stays 0.
  - ld_tid ≥ NUM_TABLES: ld_start is ignored and the FSM stays in its current state.
  - ld_valid in IDLE: ignored.
- Read: on rd_en, rd_data←(tbl_valid[rd_tid] ? mem[rd_tid][rd_addr] : 0) and rd_valid←1. Otherwise rd_data holds its value and rd_valid←0.
- Read-side boundary conditions:
  - A read of the table currently being loaded returns 0, because its tbl_valid is low.
  - A read of a different table while another is loading is unaffected.
  - rd_tid ≥ NUM_TABLES returns 0.
- Reset values: state IDLE, cnt 0, ld_ready 0, ld_busy 0, ld_done 0, rd_data 0, rd_valid 0, tbl_valid all 0.
  - Memory contents are not reset.
  - Reset mid-load abandons the load; all tables read as 0 until reloaded.

## Timing
- Read latency is 1 cycle: rd_en at edge N gives rd_data/rd_valid valid after edge N+1. Back-to-back reads sustain one per cycle.
- ld_ready rises the cycle after ld_start is sampled. Minimum load time is 65 cycles from ld_start to ld_done with no ld_valid gaps.
- tbl_valid[t] rises in the same cycle as ld_done. A read issued in that cycle already returns the real data.
- ld_valid gaps stall cnt; there is no timeout.
- Memory is inferred as a synchronous-write array of NUM_TABLES*64 words. It holds no combinational read path to outputs.

## Configuration
- QTAB_ZIGZAG_EN defined:
  - wa(cnt) = ZZ2NAT[cnt], the standard JPEG zigzag-to-natural table (a 64-entry constant LUT).
  - Tables are stored in natural order, so rd_addr is row*8+col.
- QTAB_ZIGZAG_EN undefined:
  - wa(cnt) = cnt and the LUT is not compiled.
  - Storage is in DQT order, and rd_addr is interpreted as the zigzag index.
  - The upstream block then owns the reordering.

## Test plan
- Reset, then rd_en on tables 0..3 at addr 0 → rd_data=0, rd_valid pulses one cycle after each request, tbl_valid=4'b0000.
- Load table 1 with values 1..64 and no gaps → ld_done exactly 65 cycles after ld_start, tbl_valid=4'b0010. With QTAB_ZIGZAG_EN, reads at addr 0/1/8/63 return 1/2/3/64. Without it, addr 8 returns 9.
- Load table 2 with ld_valid toggled every other cycle → 64 accepted beats, ld_done after 128+ cycles. Table 1 reads stay correct throughout.
- Start a load of table 1 (already valid), stop after 20 beats, then read table 1 → 0. Complete a fresh load → new data is returned.
- Assert ld_start with ld_tid=3 after 30 beats into table 0 → tbl_valid[0]=0, cnt restarts, ld_done follows after 64 further beats with tbl_valid[3]=1.
- Assert rst after 40 beats of a load → ld_ready, ld_busy, rd_valid and tbl_valid clear asynchronously. A post-reset read returns 0.

Source files
------------

// File: rtl/qtab_store.sv
// ============================================================================
// Module   : qtab_store
// Summary  : Multi-table run-time loadable inverse-quantization coefficient
//            store. Optional zigzag-to-natural reordering via QTAB_ZIGZAG_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module qtab_store #(
  parameter int DATA_W     = 8,
  parameter int NUM_TABLES = 4,
  localparam int TID_W     = (NUM_TABLES <= 1) ? 1 : $clog2(NUM_TABLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [TID_W-1:0]  ld_tid,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  input  logic              rd_en,
  input  logic [TID_W-1:0]  rd_tid,
  input  logic [5:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [NUM_TABLES-1:0] tbl_valid
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;
  localparam logic [TID_W:0] C_NUM_TABLES = (TID_W+1)'(NUM_TABLES);

`ifdef QTAB_ZIGZAG_EN
  localparam logic [5:0] ZZ2NAT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
`endif

  logic [0:0]            state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [TID_W-1:0]      tid_q, tid_d;
  logic [NUM_TABLES-1:0] tbl_valid_q, tbl_valid_d;
  logic                  ld_done_q, ld_done_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0] mem [NUM_TABLES][64];

  logic       w_start_ok;
  logic       w_we;
  logic [5:0] w_wa;

  // Out-of-range table ids on ld_start are ignored entirely
  assign w_start_ok = ld_start && ({1'b0, ld_tid} < C_NUM_TABLES);
  // A restart discards the beat presented in the same cycle
  assign w_we       = (state_q == ST_LOAD) && ld_valid && !w_start_ok;

`ifdef QTAB_ZIGZAG_EN
  assign w_wa = ZZ2NAT[cnt_q];
`else
  assign w_wa = cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tid_d       = tid_q;
    tbl_valid_d = tbl_valid_q;
    ld_done_d   = 1'b0;
    if (w_start_ok) begin
      state_d             = ST_LOAD;
      cnt_d               = 6'd0;
      tid_d               = ld_tid;
      tbl_valid_d[ld_tid] = 1'b0;
    end else if (w_we) begin
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'd63) begin
        state_d            = ST_IDLE;
        ld_done_d          = 1'b1;
        tbl_valid_d[tid_q] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      rd_data_d = '0;
      if (({1'b0, rd_tid} < C_NUM_TABLES) && tbl_valid_q[rd_tid]) begin
        rd_data_d = mem[rd_tid][rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      tid_q       <= '0;
      tbl_valid_q <= '0;
      ld_done_q   <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tid_q       <= tid_d;
      tbl_valid_q <= tbl_valid_d;
      ld_done_q   <= ld_done_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[tid_q][w_wa] <= ld_data;
    end
  end

  assign ld_ready  = (state_q == ST_LOAD);
  assign ld_busy   = (state_q == ST_LOAD);
  assign ld_done   = ld_done_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign tbl_valid = tbl_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_qtab_store.sv
// Directed self-checking bench for qtab_store (default 8-bit, 4 tables).
`default_nettype none

module tb_qtab_store;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_start = 1'b0;
  logic [1:0] ld_tid = '0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_ready, ld_busy, ld_done;
  logic       rd_en = 1'b0;
  logic [1:0] rd_tid = '0;
  logic [5:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] tbl_valid;

  qtab_store #(.DATA_W(8), .NUM_TABLES(4)) dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_tid(ld_tid), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .rd_en(rd_en), .rd_tid(rd_tid), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .tbl_valid(tbl_valid)
  );

  always #5 clk = ~clk;

  // Storage index of natural coefficient 8 (zigzag index 2 when reordering)
`ifdef QTAB_ZIGZAG_EN
  localparam int IDX8 = 2;
`else
  localparam int IDX8 = 8;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] tid;
    logic [5:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] t, input logic [5:0] a,
                         output logic [7:0] d, output logic v);
    rd_en   = 1'b1;
    rd_tid  = t;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] t, input logic [5:0] a,
                        input logic [7:0] exp);
    logic [7:0] d;
    logic       v;
    do_read(t, a, d, v);
    chk(name, {24'd0, d}, {24'd0, exp});
    chk({name, "_valid"}, {31'd0, v}, 32'd1);
  endtask

  task automatic start(input logic [1:0] t);
    ld_start = 1'b1;
    ld_tid   = t;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic beats(input int n, input int base);
    for (int j = 0; j < n; j++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(base + j);
      tick();
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    int   s;
    int   acc;
    bit   done;
    logic [7:0] d;
    logic       v;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_ld_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst_ld_done", {31'd0, ld_done}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_tbl_valid", {28'd0, tbl_valid}, 32'd0);
    for (int t = 0; t < 4; t++) rd_chk("rst_read", 2'(t), 6'd0, 8'd0);
    tick();
    chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);

    // Table 1, values 1..64, no gaps
    s = cyc;
    start(2'd1);
    chk("ld_ready_rise", {31'd0, ld_ready}, 32'd1);
    chk("ld_busy_rise", {31'd0, ld_busy}, 32'd1);
    beats(63, 1);
    chk("ld_done_early", {31'd0, ld_done}, 32'd0);
    beats(1, 64);
    chk("ld_done_t1", {31'd0, ld_done}, 32'd1);
    chk("load_cycles_t1", 32'(cyc - s), 32'd65);
    chk("tbl_valid_t1", {28'd0, tbl_valid}, 32'b0010);
    chk("ld_busy_end", {31'd0, ld_busy}, 32'd0);
    rd_chk("read_in_done_cycle", 2'd1, 6'd8, 8'(1 + IDX8));
    chk("ld_done_pulse", {31'd0, ld_done}, 32'd0);

    // Table 2, ld_valid every other cycle, with concurrent table 1 reads
    s = cyc;
    start(2'd2);
    acc  = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      ld_valid = (c % 2 == 0);
      ld_data  = 8'(101 + acc);
      rd_en    = 1'b1;
      rd_tid   = 2'd1;
      rd_addr  = 6'd8;
      tick();
      if (ld_valid) acc++;
      chk("t1_during_t2_load", {24'd0, rd_data}, 32'(1 + IDX8));
      if (ld_done) done = 1'b1;
    end
    ld_valid = 1'b0;
    rd_en    = 1'b0;
    chk("t2_done_seen", {31'd0, done}, 32'd1);
    chk("t2_beats", 32'(acc), 32'd64);
    chk("t2_min_cycles", {31'd0, (cyc - s) >= 128}, 32'd1);
    chk("tbl_valid_t12", {28'd0, tbl_valid}, 32'b0110);

    vecs[0] = '{2'd1, 6'd0,  8'd1};
    vecs[1] = '{2'd1, 6'd1,  8'd2};
    vecs[2] = '{2'd1, 6'd8,  8'(1 + IDX8)};
    vecs[3] = '{2'd1, 6'd63, 8'd64};
    vecs[4] = '{2'd2, 6'd0,  8'd101};
    vecs[5] = '{2'd2, 6'd8,  8'(101 + IDX8)};
    vecs[6] = '{2'd2, 6'd63, 8'd164};
    vecs[7] = '{2'd0, 6'd0,  8'd0};
    vecs[8] = '{2'd3, 6'd5,  8'd0};
    for (int i = 0; i < 9; i++) rd_chk($sformatf("vec%0d", i), vecs[i].tid, vecs[i].addr, vecs[i].exp);

    // Partial reload of table 1 invalidates it; other tables unaffected
    start(2'd1);
    beats(20, 50);
    chk("t1_invalid", {28'd0, tbl_valid}, 32'b0100);
    rd_chk("t1_partial_read", 2'd1, 6'd0, 8'd0);
    rd_chk("t2_during_t1_load", 2'd2, 6'd0, 8'd101);
    start(2'd1);
    beats(64, 65);
    chk("ld_done_t1_reload", {31'd0, ld_done}, 32'd1);
    rd_chk("t1_reload_a0", 2'd1, 6'd0, 8'd65);
    rd_chk("t1_reload_a8", 2'd1, 6'd8, 8'(65 + IDX8));
    rd_chk("t1_reload_a63", 2'd1, 6'd63, 8'd128);

    // Restart into table 3 after 30 beats of table 0; start-cycle beat dropped
    start(2'd0);
    beats(30, 1);
    ld_start = 1'b1;
    ld_tid   = 2'd3;
    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    chk("t0_abandoned", {31'd0, tbl_valid[0]}, 32'd0);
    beats(63, 10);
    chk("t3_done_early", {31'd0, ld_done}, 32'd0);
    beats(1, 73);
    chk("t3_done", {31'd0, ld_done}, 32'd1);
    chk("tbl_valid_t3", {28'd0, tbl_valid}, 32'b1110);
    rd_chk("t3_a0", 2'd3, 6'd0, 8'd10);
    rd_chk("t3_a8", 2'd3, 6'd8, 8'(10 + IDX8));
    rd_chk("t3_a63", 2'd3, 6'd63, 8'd73);
    rd_chk("t0_after_abandon", 2'd0, 6'd0, 8'd0);

    // Asynchronous reset during a load
    start(2'd2);
    rd_en  = 1'b1;
    rd_tid = 2'd1;
    beats(40, 1);
    ld_valid = 1'b1;
    chk("pre_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("arst_ld_busy", {31'd0, ld_busy}, 32'd0);
    chk("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("arst_tbl_valid", {28'd0, tbl_valid}, 32'd0);
    rd_en    = 1'b0;
    ld_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_read(2'd1, 6'd0, d, v);
    chk("post_rst_read", {24'd0, d}, 32'd0);
    chk("post_rst_valid", {31'd0, v}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
